ps_decode_sb: RTL and testbench

- Parametrised successor to the decode-stage register bank with hazard tracking.
- Holds the architectural register file plus a per-register busy/tag scoreboard, accepts NWB parallel write-back ports and forwards same-cycle write-backs.
- Stalls issue on RAW/WAW hazards and drives a registered, ready/valid decode output slot toward execute.
- Flush squashes in-flight producers by retagging.

---
 rtl/ps_decode_sb.sv | 179 +++++++++++++++++
 tb/tb_ps_decode_sb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps_decode_sb.sv
// Decode-stage register bank with busy/tag scoreboard, NWB write-back ports with
// same-cycle bypass, RAW/WAW issue stall and a registered ready/valid output slot.

module ps_decode_sb_reg #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int NWB   = 2,
  parameter int TAG_W = 2,
  parameter int IDX   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [NWB-1:0]             wb_en,
  input  logic [NWB-1:0][AW-1:0]     wb_add,
  input  logic [NWB-1:0][TAG_W-1:0]  wb_tag,
  input  logic [NWB-1:0][XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]            data,
  output logic                       busy,
  output logic [TAG_W-1:0]           tag,
  output logic                       hit,
  output logic [XLEN-1:0]            byp_data
);
  // Ascending scan: the highest-indexed hitting port overrides lower ones.
  always_comb begin
    hit      = 1'b0;
    byp_data = '0;
    for (int i = 0; i < NWB; i++) begin
      if (wb_en[i] && wb_add[i] == AW'(IDX) && busy && wb_tag[i] == tag) begin
        hit      = 1'b1;
        byp_data = wb_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
      busy <= 1'b0;
      tag  <= '0;
    end else if (flush) begin
      // Retag so any late result from a squashed producer no longer matches.
      if (busy) begin
        busy <= 1'b0;
        tag  <= tag + TAG_W'(1);
      end
    end else begin
      if (hit) begin
        data <= byp_data;
        busy <= 1'b0;
      end
      if (alloc) begin
        busy <= 1'b1;
        tag  <= tag + TAG_W'(1);
      end
    end
  end
endmodule

module ps_decode_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NWB   = 2,
  parameter int TAG_W = 2,
  parameter int PAY_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  rs1_en,
  input  logic                  rs2_en,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rs1_add,
  input  logic [AW-1:0]         rs2_add,
  input  logic [AW-1:0]         rd_add,
  input  logic [PAY_W-1:0]      in_payload,
  input  logic [NWB-1:0]        wb_en,
  input  logic [NWB*AW-1:0]     wb_add,
  input  logic [NWB*TAG_W-1:0]  wb_tag,
  input  logic [NWB*XLEN-1:0]   wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_rs1,
  output logic [XLEN-1:0]       out_rs2,
  output logic [AW-1:0]         out_rd_add,
  output logic [TAG_W-1:0]      out_rd_tag,
  output logic                  out_rd_en,
  output logic [PAY_W-1:0]      out_payload
);
  logic [NWB-1:0][AW-1:0]    wb_add_a;
  logic [NWB-1:0][TAG_W-1:0] wb_tag_a;
  logic [NWB-1:0][XLEN-1:0]  wb_data_a;
  assign wb_add_a  = wb_add;
  assign wb_tag_a  = wb_tag;
  assign wb_data_a = wb_data;

  logic [NREG-1:0][XLEN-1:0]  rf, byp;
  logic [NREG-1:0][TAG_W-1:0] tag;
  logic [NREG-1:0]            busy, hit;
  logic [NREG-1:1]            alloc;

  // x0 has no storage: constant zero, never busy, never hit.
  assign rf[0]   = '0;
  assign byp[0]  = '0;
  assign tag[0]  = '0;
  assign busy[0] = 1'b0;
  assign hit[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    ps_decode_sb_reg #(.XLEN(XLEN), .AW(AW), .NWB(NWB), .TAG_W(TAG_W), .IDX(r)) u_reg (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .alloc    (alloc[r]),
      .wb_en    (wb_en),
      .wb_add   (wb_add_a),
      .wb_tag   (wb_tag_a),
      .wb_data  (wb_data_a),
      .data     (rf[r]),
      .busy     (busy[r]),
      .tag      (tag[r]),
      .hit      (hit[r]),
      .byp_data (byp[r])
    );
  end

  logic            rs1_live, rs2_live, rd_live;
  logic            rs1_stall, rs2_stall, waw_stall, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [TAG_W-1:0] new_tag;

  assign rs1_live = rs1_en && rs1_add != '0;
  assign rs2_live = rs2_en && rs2_add != '0;
  assign rd_live  = rd_en  && rd_add  != '0;

  assign rs1_val = !rs1_live ? '0 : (hit[rs1_add] ? byp[rs1_add] : rf[rs1_add]);
  assign rs2_val = !rs2_live ? '0 : (hit[rs2_add] ? byp[rs2_add] : rf[rs2_add]);

  assign rs1_stall = rs1_live && busy[rs1_add] && !hit[rs1_add];
  assign rs2_stall = rs2_live && busy[rs2_add] && !hit[rs2_add];
  assign waw_stall = rd_live  && busy[rd_add]  && !hit[rd_add];

  assign in_ready = !flush && !rs1_stall && !rs2_stall && !waw_stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign new_tag  = rd_live ? tag[rd_add] + TAG_W'(1) : '0;

  always_comb begin
    alloc = '0;
    for (int r = 1; r < NREG; r++) alloc[r] = accept && rd_live && rd_add == AW'(r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd_add  <= '0;
      out_rd_tag  <= '0;
      out_rd_en   <= 1'b0;
      out_payload <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_rs1     <= rs1_val;
      out_rs2     <= rs2_val;
      out_rd_add  <= rd_add;
      out_rd_tag  <= new_tag;
      out_rd_en   <= rd_en;
      out_payload <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps_decode_sb.sv
// Bench for ps_decode_sb: directed vector table, a stall/reset sequence, then
// random traffic checked against an array-based scoreboard model.

module tb_ps_decode_sb;
  localparam int XLEN = 32, NREG = 32, AW = 5, NWB = 2, TAG_W = 2, PAY_W = 24;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, rs1_en, rs2_en, rd_en;
  logic [AW-1:0] rs1_add, rs2_add, rd_add;
  logic [PAY_W-1:0] in_payload;
  logic [NWB-1:0] wb_en;
  logic [NWB*AW-1:0] wb_add;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*XLEN-1:0] wb_data;
  logic out_valid, out_ready, out_rd_en;
  logic [XLEN-1:0] out_rs1, out_rs2;
  logic [AW-1:0] out_rd_add;
  logic [TAG_W-1:0] out_rd_tag;
  logic [PAY_W-1:0] out_payload;

  ps_decode_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NWB(NWB), .TAG_W(TAG_W), .PAY_W(PAY_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en), .rs1_add(rs1_add), .rs2_add(rs2_add),
    .rd_add(rd_add), .in_payload(in_payload), .wb_en(wb_en), .wb_add(wb_add), .wb_tag(wb_tag),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd_add(out_rd_add), .out_rd_tag(out_rd_tag), .out_rd_en(out_rd_en),
    .out_payload(out_payload)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic fl, iv, r1e; logic [4:0] r1; logic r2e; logic [4:0] r2; logic rde; logic [4:0] rd;
    logic [1:0] wbe; logic [4:0] wa0, wa1; logic [1:0] wt0, wt1; logic [31:0] wd0, wd1;
    logic ordy, e_ir, e_ov; logic [31:0] e_rs1, e_rs2; logic [1:0] e_tag;
  } vec_t;

  vec_t tbl[17];

  task automatic drive(input vec_t v, input int pay);
    flush = v.fl; in_valid = v.iv; rs1_en = v.r1e; rs1_add = v.r1; rs2_en = v.r2e; rs2_add = v.r2;
    rd_en = v.rde; rd_add = v.rd; wb_en = v.wbe; wb_add = {v.wa1, v.wa0}; wb_tag = {v.wt1, v.wt0};
    wb_data = {v.wd1, v.wd0}; out_ready = v.ordy; in_payload = PAY_W'(pay);
  endtask

  // Scoreboard model state
  logic [31:0] m_rf[NREG];
  bit          m_busy[NREG];
  logic [1:0]  m_tag[NREG];
  bit          h[NREG];
  logic [31:0] hd[NREG];
  bit m_ov, m_rde; logic [31:0] m_rs1, m_rs2; logic [4:0] m_rd; logic [1:0] m_rtag; logic [23:0] m_pay;

  function automatic logic [31:0] rd_val(input bit en, input int a);
    if (!en || a == 0) return 0;
    return h[a] ? hd[a] : m_rf[a];
  endfunction

  function automatic bit stall(input bit en, input int a);
    return en && a != 0 && m_busy[a] && !h[a];
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //          fl iv r1e r1 r2e r2 rde rd  wbe    wa0 wa1 wt0 wt1 wd0       wd1      ordy ir ov rs1       rs2      tag
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 0, 0,        0,       0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 5, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 0,        0,       1};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 1, 0, 32'h1234, 0,       1, 1, 0, 0,        0,       0};
    tbl[3]  = '{0, 1, 1, 5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 32'h1234, 0,       0};
    tbl[4]  = '{0, 1, 0, 5, 0, 0, 1, 7, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 0,        0,       1};
    tbl[5]  = '{0, 1, 1, 7, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0,        0,       1, 0, 0, 0,        0,       0};
    tbl[6]  = '{0, 1, 1, 7, 0, 0, 0, 0, 2'b10, 0, 7, 0, 1, 0,        32'hCAFE,1, 1, 1, 32'hCAFE, 0,       0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 1, 3, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 0,        0,       1};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 1, 3, 2'b00, 0, 0, 0, 0, 0,        0,       1, 0, 0, 0,        0,       0};
    tbl[9]  = '{0, 1, 1, 3, 0, 0, 1, 3, 2'b01, 3, 0, 1, 0, 32'hDEAD, 0,       1, 1, 1, 0,        0,       3};
    tbl[10] = '{0, 1, 0, 0, 0, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 0,        0,       1};
    tbl[11] = '{0, 1, 1, 9, 0, 0, 0, 0, 2'b11, 9, 9, 1, 1, 32'h11,   32'h22,  1, 1, 1, 32'h22,   0,       0};
    tbl[12] = '{0, 1, 0, 0, 1, 9, 0, 0, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 0,        32'h22,  0};
    tbl[13] = '{0, 1, 1, 0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0, 32'hBAD,  0,       1, 1, 1, 0,        0,       0};
    tbl[14] = '{0, 1, 1, 0, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0,        0,       1, 1, 1, 0,        32'h1234,0};
    tbl[15] = '{0, 1, 0, 0, 0, 0, 1, 3, 2'b00, 0, 0, 0, 0, 0,        0,       1, 0, 0, 0,        0,       0};
    tbl[16] = '{0, 1, 1, 3, 0, 0, 1, 3, 2'b01, 3, 0, 3, 0, 32'h77,   0,       1, 1, 1, 32'h77,   0,       0};

    reset = 1'b1;
    drive(tbl[0], 0);
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_rs1", out_rs1, 0);
    chk("reset_out_rs2", out_rs2, 0);
    chk("reset_out_rd_tag", 32'(out_rd_tag), 0);
    chk("reset_out_payload", 32'(out_payload), 0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i], i);
      #1 chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      @(posedge clk);
      #1 chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_out_rs1", i), out_rs1, tbl[i].e_rs1);
        chk($sformatf("v%0d_out_rs2", i), out_rs2, tbl[i].e_rs2);
        chk($sformatf("v%0d_out_rd_tag", i), 32'(out_rd_tag), 32'(tbl[i].e_tag));
        chk($sformatf("v%0d_out_rd_add", i), 32'(out_rd_add), 32'(tbl[i].rd));
        chk($sformatf("v%0d_out_rd_en", i), 32'(out_rd_en), 32'(tbl[i].rde));
        chk($sformatf("v%0d_out_payload", i), 32'(out_payload), i);
      end
    end

    // Slot held by execute back-pressure; new instruction must wait, outputs frozen.
    @(negedge clk);
    in_valid = 1; rs1_en = 1; rs1_add = 5; rs2_en = 0; rd_en = 0; wb_en = 0; flush = 0;
    out_ready = 0; in_payload = 24'hABC;
    for (int c = 0; c < 4; c++) begin
      #1 chk("stall_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_rs1", out_rs1, 32'h77);
      chk("stall_out_rd_add", 32'(out_rd_add), 3);
      chk("stall_out_payload", 32'(out_payload), 16);
      @(negedge clk);
    end
    out_ready = 1;
    #1 chk("release_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(out_valid), 1);
    chk("release_out_rs1", out_rs1, 32'h1234);
    chk("release_out_payload", 32'(out_payload), 32'hABC);

    // Asynchronous reset mid-operation with a full slot
    @(negedge clk);
    in_valid = 0;
    #2 reset = 1;
    #1;
    chk("async_reset_out_valid", 32'(out_valid), 0);
    chk("async_reset_out_rs1", out_rs1, 0);
    chk("async_reset_out_payload", 32'(out_payload), 0);
    @(negedge clk);
    reset = 0;

    for (int r = 0; r < NREG; r++) begin m_rf[r] = 0; m_busy[r] = 0; m_tag[r] = 0; end
    m_ov = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_rtag = 0; m_rde = 0; m_pay = 0;

    for (int n = 0; n < 3000; n++) begin
      bit e_ir, acc;
      logic [31:0] v1, v2;
      logic [4:0] wa[2]; logic [1:0] wt[2]; logic [31:0] wd[2];
      @(negedge clk);
      flush = ($urandom_range(0, 19) == 0);
      in_valid = $urandom_range(0, 1); out_ready = ($urandom_range(0, 3) != 0);
      rs1_en = $urandom_range(0, 1); rs2_en = $urandom_range(0, 1); rd_en = $urandom_range(0, 1);
      rs1_add = 5'($urandom_range(0, 7)); rs2_add = 5'($urandom_range(0, 7)); rd_add = 5'($urandom_range(0, 7));
      in_payload = 24'($urandom);
      for (int p = 0; p < 2; p++) begin
        wa[p] = 5'($urandom_range(0, 7));
        wt[p] = ($urandom_range(0, 3) != 0) ? m_tag[wa[p]] : 2'($urandom);
        wd[p] = $urandom;
        wb_en[p] = $urandom_range(0, 1);
      end
      wb_add = {wa[1], wa[0]}; wb_tag = {wt[1], wt[0]}; wb_data = {wd[1], wd[0]};

      for (int r = 0; r < NREG; r++) begin h[r] = 0; hd[r] = 0; end
      for (int p = 0; p < 2; p++)
        if (wb_en[p] && wa[p] != 0 && m_busy[wa[p]] && wt[p] == m_tag[wa[p]]) begin
          h[wa[p]] = 1; hd[wa[p]] = wd[p];
        end
      e_ir = !flush && !stall(rs1_en, rs1_add) && !stall(rs2_en, rs2_add) && !stall(rd_en, rd_add)
             && (!m_ov || out_ready);
      acc = in_valid && e_ir;
      v1 = rd_val(rs1_en, rs1_add);
      v2 = rd_val(rs2_en, rs2_add);
      #1 chk("rnd_in_ready", 32'(in_ready), 32'(e_ir));

      if (flush) begin
        m_ov = 0;
        for (int r = 0; r < NREG; r++) if (m_busy[r]) begin m_busy[r] = 0; m_tag[r] = m_tag[r] + 1; end
      end else begin
        for (int r = 0; r < NREG; r++) if (h[r]) begin m_rf[r] = hd[r]; m_busy[r] = 0; end
        if (acc) begin
          m_ov = 1; m_rs1 = v1; m_rs2 = v2; m_rd = rd_add; m_rde = rd_en; m_pay = in_payload;
          m_rtag = 0;
          if (rd_en && rd_add != 0) begin
            m_tag[rd_add] = m_tag[rd_add] + 1; m_busy[rd_add] = 1; m_rtag = m_tag[rd_add];
          end
        end else if (out_ready) m_ov = 0;
      end

      @(posedge clk);
      #1 chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rnd_out_rs1", out_rs1, m_rs1);
        chk("rnd_out_rs2", out_rs2, m_rs2);
        chk("rnd_out_rd_add", 32'(out_rd_add), 32'(m_rd));
        chk("rnd_out_rd_tag", 32'(out_rd_tag), 32'(m_rtag));
        chk("rnd_out_rd_en", 32'(out_rd_en), 32'(m_rde));
        chk("rnd_out_payload", 32'(out_payload), 32'(m_pay));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
